prog_sequencer: RTL and testbench

//  Run controller for the single-cycle core (top). Launches the multiply, pattern-search and

---
 rtl/seq_pkg.sv | 22 ++
 rtl/sat_counter.sv | 19 +
 rtl/prog_sequencer.sv | 132 +++++++++++++
 tb/tb_prog_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding, program id type and program start-address table for prog_sequencer
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_LAUNCH,
        S_RUN,
        S_RECORD,
        S_FINISH
    } seq_state_t;

    typedef logic [2:0] prog_id_t;

    localparam int DEFAULT_TIMEOUT = 4000;

    // Entry points from the assembler map: multiply at 0, pattern search after multiply, closest pair after search
    localparam logic [9:0] PROG_START [8] = '{
        10'd0, 10'd36, 10'd92, 10'd160, 10'd224, 10'd288, 10'd352, 10'd416
    };

endpackage

// File: rtl/sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= '0;
        else if (enable && count != '1)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer: batch run controller for the core; PERF_LOG_EN adds a per-program cycle log (rd_sel/rd_cycles)
module prog_sequencer
    import seq_pkg::*;
#(
    parameter int NUM_PROGS = 3,
    parameter int PC_W      = 10,
    parameter int CYC_W     = 16,
    parameter int RST_CYC   = 2,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 go,
    input  logic [NUM_PROGS-1:0] prog_mask,
    input  logic                 core_done,
`ifdef PERF_LOG_EN
    input  logic [2:0]           rd_sel,
    output logic [CYC_W-1:0]     rd_cycles,
`endif
    output logic                 core_reset,
    output logic [PC_W-1:0]      core_pc_init,
    output prog_id_t             cur_prog,
    output logic                 busy,
    output logic                 batch_done,
    output logic [NUM_PROGS-1:0] timeout_err,
    output logic [CYC_W-1:0]     last_cycles
);

    localparam int LW = $clog2(RST_CYC + 1);

    seq_state_t           state, nxt;
    logic [NUM_PROGS-1:0] mask;
    logic [CYC_W-1:0]     cnt;
    logic [LW-1:0]        lcnt;
    prog_id_t             sel;
    logic                 found, done_hit, to_hit;

    sat_counter #(.W(CYC_W)) u_cnt (
        .clk    (clk),
        .rst    (reset),
        .clear  (state != S_RUN),
        .enable (state == S_RUN),
        .count  (cnt)
    );

    // Serviced bits are cleared, so the lowest remaining bit is always the next program
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = NUM_PROGS - 1; i >= 0; i--)
            if (mask[i]) begin
                sel   = prog_id_t'(i);
                found = 1'b1;
            end
    end

    // cnt is 0 only on the first RUN cycle, where a stale done is ignored
    assign done_hit = state == S_RUN && cnt != '0 && core_done;
    assign to_hit   = state == S_RUN && cnt == CYC_W'(TIMEOUT - 1);

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   nxt = go ? S_SELECT : S_IDLE;
            S_SELECT: nxt = found ? S_LAUNCH : S_FINISH;
            S_LAUNCH: nxt = lcnt == LW'(RST_CYC - 1) ? S_RUN : S_LAUNCH;
            S_RUN:    nxt = done_hit || to_hit ? S_RECORD : S_RUN;
            S_RECORD: nxt = S_SELECT;
            default:  nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            core_reset   <= 1'b1;
            core_pc_init <= '0;
            cur_prog     <= '0;
            busy         <= 1'b0;
            batch_done   <= 1'b0;
            timeout_err  <= '0;
            last_cycles  <= '0;
            mask         <= '0;
            lcnt         <= '0;
        end else begin
            core_reset <= nxt != S_RUN;
            batch_done <= state == S_SELECT && !found;
            lcnt       <= state == S_LAUNCH ? lcnt + 1'b1 : '0;
            if (state == S_IDLE && go) begin
                mask        <= prog_mask;
                timeout_err <= '0;
                cur_prog    <= '0;
                busy        <= 1'b1;
            end
            if (state == S_SELECT) begin
                if (found) begin
                    cur_prog     <= sel;
                    core_pc_init <= PC_W'(PROG_START[sel]);
                end else
                    busy <= 1'b0;
            end
            if (to_hit && !done_hit)
                timeout_err[cur_prog] <= 1'b1;
            if (state == S_RECORD) begin
                last_cycles    <= cnt;
                mask[cur_prog] <= 1'b0;
                cur_prog       <= cur_prog + 3'd1;
            end
        end
    end

`ifdef PERF_LOG_EN
    logic [CYC_W-1:0] perf [NUM_PROGS];

    always_ff @(posedge clk) begin
        if (reset || (state == S_IDLE && go)) begin
            for (int i = 0; i < NUM_PROGS; i++)
                perf[i] <= '0;
        end else if (state == S_RECORD)
            perf[cur_prog] <= cnt;
    end

    assign rd_cycles = int'(rd_sel) < NUM_PROGS ? perf[rd_sel] : '0;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: table-driven and random batches against a per-program cycle model, plus reset corner cases
module tb_prog_sequencer;
    import seq_pkg::*;

    localparam int NP  = 3;
    localparam int PW  = 10;
    localparam int CW  = 16;
    localparam int RC  = 2;
    localparam int TO  = 130;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          go = 1'b0;
    logic [NP-1:0] prog_mask = '0;
    logic          core_done = 1'b0;
    logic          core_reset;
    logic [PW-1:0] core_pc_init;
    logic [2:0]    cur_prog;
    logic          busy;
    logic          batch_done;
    logic [NP-1:0] timeout_err;
    logic [CW-1:0] last_cycles;
`ifdef PERF_LOG_EN
    logic [2:0]    rd_sel = '0;
    logic [CW-1:0] rd_cycles;
`endif

    prog_sequencer #(
        .NUM_PROGS (NP),
        .PC_W      (PW),
        .CYC_W     (CW),
        .RST_CYC   (RC),
        .TIMEOUT   (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .go           (go),
        .prog_mask    (prog_mask),
        .core_done    (core_done),
`ifdef PERF_LOG_EN
        .rd_sel       (rd_sel),
        .rd_cycles    (rd_cycles),
`endif
        .core_reset   (core_reset),
        .core_pc_init (core_pc_init),
        .cur_prog     (cur_prog),
        .busy         (busy),
        .batch_done   (batch_done),
        .timeout_err  (timeout_err),
        .last_cycles  (last_cycles)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int model_last = 0;
    int model_perf [NP];

    typedef struct {
        logic [2:0] m;
        int         l0, l1, l2;
        bit         stale;
        int         err, last, n;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: each selected program runs min(latency, TO) RUN cycles, at least 2 since cycle 1 ignores done;
    // latency 0 (never done) or beyond TO is a timeout. Stub core counts its own RUN cycles.
    task automatic do_batch(input logic [2:0] m, input int l0, input int l1, input int l2,
                            input bit stale, input int t_err, input int t_last, input int t_n);
        int lat [3];
        int eprog [$];
        int ecyc [$];
        int eerr, t, k, nl, pend, got, p, curc, r, en;
        lat = '{l0, l1, l2};
        eerr = 0;
        for (int i = 0; i < NP; i++) begin
            model_perf[i] = 0;
            if (m[i]) begin
                r = (lat[i] == 0 || lat[i] > TO) ? TO : (lat[i] < 2 ? 2 : lat[i]);
                if (lat[i] == 0 || lat[i] > TO) eerr |= 1 << i;
                eprog.push_back(i);
                ecyc.push_back(r);
                model_last = r;
                model_perf[i] = r;
            end
        end
        en = eprog.size();
        t = 0; k = 0; nl = 0; pend = 0; got = 0; p = 0; curc = 0;
        @(negedge clk);
        go = 1'b1;
        prog_mask = m;
        core_done = stale;
        while (t < 1000) begin
            @(negedge clk);
            go = 1'b0;
            t++;
            if (pend != 0) begin
                chk("last_cycles", int'(last_cycles), curc);
                pend = 0;
            end
            if (!core_reset) begin
                if (k == 0) begin
                    nl++;
                    if (nl == 1) chk("release_latency", t, 2 + RC);
                    if (eprog.size() > 0) begin
                        p = eprog.pop_front();
                        curc = ecyc.pop_front();
                        chk("cur_prog", int'(cur_prog), p);
                        chk("core_pc_init", int'(core_pc_init), int'(PROG_START[p]));
                    end else
                        chk("extra_launch", nl, en);
                end
                k++;
                core_done = (k == 1 && stale) || (lat[p] != 0 && k >= lat[p]);
            end else begin
                if (k > 0) begin
                    chk("run_length", k, curc);
                    pend = 1;
                    k = 0;
                end
                core_done = stale;
            end
            if (batch_done) begin
                got = 1;
                break;
            end
        end
        if (got == 0)
            chk("batch_done_seen", 0, 1);
        else begin
            if (m == 3'b000) chk("empty_batch_latency", t, 2);
            chk("busy_at_finish", int'(busy), 0);
            chk("timeout_err", int'(timeout_err), eerr);
            chk("launch_count", nl, en);
            chk("last_at_finish", int'(last_cycles), model_last);
            if (t_err >= 0) chk("tbl_timeout_err", int'(timeout_err), t_err);
            if (t_last >= 0) chk("tbl_last_cycles", int'(last_cycles), t_last);
            if (t_n >= 0) chk("tbl_launches", nl, t_n);
        end
        @(negedge clk);
        chk("batch_done_pulse_width", int'(batch_done), 0);
        core_done = 1'b0;
`ifdef PERF_LOG_EN
        for (int i = 0; i < NP; i++) begin
            rd_sel = 3'(i);
            #1;
            chk("rd_cycles", int'(rd_cycles), model_perf[i]);
        end
`endif
    endtask

    initial begin
        int w;
        tbl[0] = '{3'b111, 40, 70, 120, 1'b0, 0, 120, 3};
        tbl[1] = '{3'b101, 40, 70, 120, 1'b0, 0, 120, 2};
        tbl[2] = '{3'b111, 40, 0, 60, 1'b0, 2, 60, 3};
        tbl[3] = '{3'b111, 1, 30, 1, 1'b1, 0, 2, 3};
        tbl[4] = '{3'b000, 9, 9, 9, 1'b0, 0, 2, 0};
        tbl[5] = '{3'b010, 0, 0, 0, 1'b0, 2, 130, 1};
        tbl[6] = '{3'b100, 5, 5, 130, 1'b0, 0, 130, 1};
        tbl[7] = '{3'b001, 129, 0, 0, 1'b0, 0, 129, 1};
        tbl[8] = '{3'b110, 0, 200, 0, 1'b0, 6, 130, 2};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_core_reset", int'(core_reset), 1);
        chk("rst_pc", int'(core_pc_init), 0);
        chk("rst_cur_prog", int'(cur_prog), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_batch_done", int'(batch_done), 0);
        chk("rst_timeout_err", int'(timeout_err), 0);
        chk("rst_last_cycles", int'(last_cycles), 0);

        for (int i = 0; i < 9; i++)
            do_batch(tbl[i].m, tbl[i].l0, tbl[i].l1, tbl[i].l2, tbl[i].stale,
                     tbl[i].err, tbl[i].last, tbl[i].n);

        // Program 0 never finishes (timeout), then reset lands in the middle of program 1
        @(negedge clk);
        go = 1'b1;
        prog_mask = 3'b111;
        core_done = 1'b0;
        @(negedge clk);
        go = 1'b0;
        w = 0;
        while (!(cur_prog == 3'd1 && !core_reset) && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("reach_prog1_run", int'(w < 400), 1);
        repeat (3) @(negedge clk);
        go = 1'b1;
        prog_mask = 3'b000;
        @(negedge clk);
        go = 1'b0;
        chk("busy_go_cur_prog", int'(cur_prog), 1);
        chk("busy_go_core_reset", int'(core_reset), 0);
        chk("busy_go_busy", int'(busy), 1);
        chk("busy_go_err_kept", int'(timeout_err), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_core_reset", int'(core_reset), 1);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_batch_done", int'(batch_done), 0);
        chk("mid_rst_err", int'(timeout_err), 0);
        chk("mid_rst_last", int'(last_cycles), 0);
        w = 0;
        repeat (10) begin
            @(negedge clk);
            w += int'(batch_done) + int'(!core_reset);
        end
        chk("mid_rst_quiet", w, 0);
        model_last = 0;

        for (int i = 0; i < 6; i++)
            do_batch(3'($urandom_range(0, 7)),
                     ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 140)),
                     ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 140)),
                     ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 140)),
                     1'($urandom_range(0, 1)), -1, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
